// File: rtl/uart_rx_hold_if.sv
// Bus between the UART receive/hold block and the CPU input port: serial line and ack in,
// held byte plus status flags out.
interface uart_rx_hold_if;
   logic       rx;
   logic       in_ack;
   logic [7:0] data_out;
   logic       full;
   logic       overrun;
   logic       frame_err;
   logic       zero_drop;

   modport master (
      output rx, in_ack,
      input  data_out, full, overrun, frame_err, zero_drop
   );

   modport slave (
      input  rx, in_ack,
      output data_out, full, overrun, frame_err, zero_drop
   );
endinterface

// File: rtl/uart_rx_hold.sv
// 8N1 UART receiver feeding a one-byte holding slot. The slot reads 8'h00 when empty,
// and the CPU's in_ack releases it.
module uart_rx_hold #(
   parameter int CLKS_PER_BIT = 868,
   parameter int SYNC_STAGES  = 2
) (
   input logic           clk,
   input logic           rst_n,
   uart_rx_hold_if.slave rx_if
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] HALF_M1  = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [1:0]             rst_sync_q;
   logic                   rst_int_n;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;

   state_t      state_q;
   logic [CW-1:0] cnt_q;
   logic [2:0]  bit_q;
   logic [7:0]  shift_q;
   logic        frame_err_q;
   logic        zero_drop_q;

   logic        stop_hit;
   logic        deliver;
   logic [7:0]  data_q, data_d;
   logic        full_q, full_d;
   logic        overrun_q, overrun_d;

   // Reset asserts asynchronously but releases only on a clock edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_int_n = rst_sync_q[1];

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], rx_if.rx};
      end
   end

   assign rxs = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         frame_err_q <= 1'b0;
         zero_drop_q <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         zero_drop_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (!rxs) begin
                  state_q <= START;
                  cnt_q   <= '0;
                  bit_q   <= '0;
               end
            end
            // A start bit that is high again at mid-bit was only a glitch.
            START: begin
               if (cnt_q == HALF_M1) begin
                  cnt_q   <= '0;
                  state_q <= rxs ? IDLE : DATA;
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            DATA: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_q   <= '0;
                  shift_q <= {rxs, shift_q[7:1]};
                  if (bit_q == 3'd7) begin
                     bit_q   <= '0;
                     state_q <= STOP;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                  end
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            STOP: begin
               if (cnt_q == LAST_CNT) begin
                  cnt_q       <= '0;
                  state_q     <= IDLE;
                  frame_err_q <= !rxs;
                  zero_drop_q <= rxs && (shift_q == 8'h00);
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign stop_hit = (state_q == STOP) && (cnt_q == LAST_CNT);
   assign deliver  = stop_hit && rxs && (shift_q != 8'h00);

   // An ack in the delivery cycle frees the slot before the new byte lands.
   always_comb begin
      data_d    = data_q;
      full_d    = full_q;
      overrun_d = overrun_q;
      if (rx_if.in_ack && full_q) begin
         data_d    = 8'h00;
         full_d    = 1'b0;
         overrun_d = 1'b0;
      end
      if (deliver) begin
         if (!full_d) begin
            data_d = shift_q;
            full_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_int_n) begin
      if (!rst_int_n) begin
         data_q    <= 8'h00;
         full_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         data_q    <= data_d;
         full_q    <= full_d;
         overrun_q <= overrun_d;
      end
   end

   assign rx_if.data_out  = data_q;
   assign rx_if.full      = full_q;
   assign rx_if.overrun   = overrun_q;
   assign rx_if.frame_err = frame_err_q;
   assign rx_if.zero_drop = zero_drop_q;

endmodule

// File: tb/tb_uart_rx_hold.sv
// Scoreboard bench for uart_rx_hold: frames are driven on rx, the slot model predicts every
// output change and a negedge monitor compares what the DUT presents.
module tb_uart_rx_hold;
   localparam int CPB  = 16;
   localparam int SYNC = 2;
   // Start drive edge to mid-stop decision edge: synchroniser, idle detect, half bit, 9 bits.
   localparam int DLY  = SYNC + 1 + CPB / 2 + 9 * CPB;

   localparam int K_SLOT = 0;
   localparam int K_FE   = 1;
   localparam int K_ZD   = 2;

   typedef struct {
      int         kind;
      logic [7:0] data;
      logic       full;
      logic       ovr;
      int         cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   errors;
   bit   mon_en;
   exp_t sb[$];

   logic [7:0] m_data;
   logic       m_full;
   logic       m_ovr;

   logic [7:0] p_data;
   logic       p_full;
   logic       p_ovr;

   uart_rx_hold_if bus_if ();

   uart_rx_hold #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rx_if (bus_if.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1);
   end

   task automatic push_slot(input logic [7:0] d, input logic f, input logic o, input int at);
      exp_t e;
      if (d != m_data || f != m_full || o != m_ovr) begin
         e.kind = K_SLOT; e.data = d; e.full = f; e.ovr = o; e.cyc = at;
         sb.push_back(e);
      end
      m_data = d; m_full = f; m_ovr = o;
   endtask

   task automatic push_flag(input int kind, input int at);
      exp_t e;
      e.kind = kind; e.data = m_data; e.full = m_full; e.ovr = m_ovr; e.cyc = at;
      sb.push_back(e);
   endtask

   // Slot rules: ack empties a full slot; a good nonzero byte loads an empty slot,
   // otherwise it is lost and overrun latches.
   task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit ack, input int at);
      logic [7:0] nd;
      logic       nf;
      logic       no;
      if (!stop_ok) begin
         push_flag(K_FE, at);
      end else if (b == 8'h00) begin
         push_flag(K_ZD, at);
      end else begin
         nd = m_data; nf = m_full; no = m_ovr;
         if (ack && nf) begin
            nd = 8'h00; nf = 1'b0; no = 1'b0;
         end
         if (!nf) begin
            nd = b; nf = 1'b1;
         end else begin
            no = 1'b1;
         end
         push_slot(nd, nf, no, at);
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok, input bit ack_same);
      @(posedge clk);
      #1;
      model_frame(b, stop_ok, ack_same, cyc + DLY);
      for (int i = 0; i < 10; i++) begin
         if (i == 0) bus_if.rx = 1'b0;
         else if (i == 9) bus_if.rx = stop_ok;
         else bus_if.rx = b[i-1];
         repeat (CPB) @(posedge clk);
         #1;
      end
      bus_if.rx = 1'b1;
   endtask

   task automatic pulse_ack();
      @(posedge clk);
      #1;
      bus_if.in_ack = 1'b1;
      if (m_full) push_slot(8'h00, 1'b0, 1'b0, cyc + 1);
      @(posedge clk);
      #1;
      bus_if.in_ack = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %02h, expected %02h", name, got, want);
      end
   endtask

   task automatic observe(input int kind, input string name);
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got data=%02h full=%0d ovr=%0d at cyc=%0d, expected no event",
                  name, bus_if.data_out, bus_if.full, bus_if.overrun, cyc);
         return;
      end
      e = sb.pop_front();
      if (e.kind != kind || bus_if.data_out !== e.data || bus_if.full !== e.full ||
          bus_if.overrun !== e.ovr || (e.cyc >= 0 && e.cyc != cyc)) begin
         errors++;
         $display("FAIL %s: got kind=%0d data=%02h full=%0d ovr=%0d cyc=%0d, expected kind=%0d data=%02h full=%0d ovr=%0d cyc=%0d",
                  name, kind, bus_if.data_out, bus_if.full, bus_if.overrun, cyc,
                  e.kind, e.data, e.full, e.ovr, e.cyc);
      end
   endtask

   initial begin
      p_data = 8'h00; p_full = 1'b0; p_ovr = 1'b0;
      forever begin
         @(negedge clk);
         if (mon_en) begin
            if (bus_if.frame_err === 1'b1) observe(K_FE, "frame_err");
            if (bus_if.zero_drop === 1'b1) observe(K_ZD, "zero_drop");
            if (bus_if.data_out !== p_data || bus_if.full !== p_full || bus_if.overrun !== p_ovr) begin
               observe(K_SLOT, "slot");
               chk("full_vs_data", {7'd0, bus_if.full}, {7'd0, bus_if.data_out != 8'h00});
            end
            p_data = bus_if.data_out;
            p_full = bus_if.full;
            p_ovr  = bus_if.overrun;
         end
      end
   end

   initial begin
      logic [7:0] b;
      bit         ok;
      checks = 0; errors = 0; mon_en = 1'b0;
      m_data = 8'h00; m_full = 1'b0; m_ovr = 1'b0;
      rst_n = 1'b0;
      bus_if.rx = 1'b1;
      bus_if.in_ack = 1'b0;
      idle(4);
      chk("rst_data", bus_if.data_out, 8'h00);
      chk("rst_full", {7'd0, bus_if.full}, 8'h00);
      chk("rst_ovr", {7'd0, bus_if.overrun}, 8'h00);
      chk("rst_fe", {7'd0, bus_if.frame_err}, 8'h00);
      chk("rst_zd", {7'd0, bus_if.zero_drop}, 8'h00);
      rst_n = 1'b1;
      mon_en = 1'b1;
      idle(8);

      // 1: plain receive then release
      send_frame(8'hA5, 1'b1, 1'b0);
      pulse_ack();
      idle(2 * CPB);
      // 2: overrun while full
      send_frame(8'h3C, 1'b1, 1'b0);
      idle(CPB);
      send_frame(8'h81, 1'b1, 1'b0);
      pulse_ack();
      idle(2 * CPB);
      // 3: bad stop bit, then recovery
      send_frame(8'h5A, 1'b0, 1'b0);
      idle(2 * CPB);
      send_frame(8'h11, 1'b1, 1'b0);
      pulse_ack();
      idle(2 * CPB);
      // 4: short glitch on the line
      bus_if.rx = 1'b0;
      idle(4);
      bus_if.rx = 1'b1;
      idle(2 * CPB);
      send_frame(8'h7E, 1'b1, 1'b0);
      pulse_ack();
      idle(2 * CPB);
      // 5: zero byte dropped; ack coinciding with delivery
      send_frame(8'h00, 1'b1, 1'b0);
      idle(CPB);
      send_frame(8'h42, 1'b1, 1'b0);
      idle(CPB);
      fork
         send_frame(8'hC3, 1'b1, 1'b1);
         begin
            @(posedge clk);
            repeat (DLY - 1) @(posedge clk);
            #1 bus_if.in_ack = 1'b1;
            @(posedge clk);
            #1 bus_if.in_ack = 1'b0;
         end
      join
      idle(2 * CPB);
      chk("ack_same_data", bus_if.data_out, 8'hC3);
      chk("ack_same_ovr", {7'd0, bus_if.overrun}, 8'h00);

      // 6: reset in the middle of a frame of 0xF0 (low nibble zero)
      bus_if.rx = 1'b0;
      idle(CPB + 2 * CPB + 8);
      push_slot(8'h00, 1'b0, 1'b0, -1);
      rst_n = 1'b0;
      #1;
      chk("midrst_data", bus_if.data_out, 8'h00);
      chk("midrst_full", {7'd0, bus_if.full}, 8'h00);
      chk("midrst_ovr", {7'd0, bus_if.overrun}, 8'h00);
      bus_if.rx = 1'b1;
      idle(5);
      rst_n = 1'b1;
      idle(2 * CPB);
      send_frame(8'h09, 1'b1, 1'b0);
      idle(CPB);
      chk("after_rst_data", bus_if.data_out, 8'h09);
      pulse_ack();
      idle(CPB);

      // Random frames, some back-to-back, some with bad stop bits or zero bytes
      for (int n = 0; n < 14; n++) begin
         b  = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 4) == 0) b = 8'h00;
         ok = ($urandom_range(0, 5) != 0);
         send_frame(b, ok, 1'b0);
         if (!ok) idle(CPB);
         else if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 5));
         if ($urandom_range(0, 1) == 1) pulse_ack();
      end

      idle(4 * CPB);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending events, expected 0", sb.size());
      end
      chk("final_data", bus_if.data_out, m_data);
      chk("final_ovr", {7'd0, bus_if.overrun}, {7'd0, m_ovr});
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
